// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t      : FSM states (IDLE, SHIFT, DONE)
//   BCD_W/BIN_W  : packed two-digit BCD width / binary result width
//   N_ITER       : shift iterations per conversion
//   bcd_valid()  : true when both BCD digits are 0..9
package bcd2bin_seq_pkg;

    localparam int BCD_W  = 8;
    localparam int BIN_W  = 7;
    localparam int N_ITER = 7;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] w);
        return (w[7:4] <= 4'd9) && (w[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble.
//   d : shifted BCD digit
//   q : d - 3 when d >= 8, else d unchanged
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d[3]) begin
            q = d - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential two-digit BCD to 7-bit binary converter (reverse double-dabble).
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   start   : request conversion of bcd_in (sampled only in IDLE)
//   bcd_in  : packed BCD, [7:4] tens, [3:0] units
//   busy    : high in SHIFT and DONE
//   done    : one-cycle pulse, bin_out/err valid
//   bin_out : binary result, held until the next accepted start
//   err     : accepted word had a digit > 9
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin_out,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [BCD_W-1:0] bcd_reg;
    logic [BIN_W-1:0] bin_reg;
    logic [CNT_W-1:0] cnt;

    logic             in_valid;
    logic [BCD_W-1:0] sh_bcd;
    logic [BIN_W-1:0] sh_bin;
    logic [3:0]       tens_adj;
    logic [3:0]       units_adj;

    assign in_valid = bcd_valid(bcd_in);

    // {bcd_reg, bin_reg} shifted right by one; the BCD LSB enters the binary MSB.
    assign sh_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
    assign sh_bin = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    bcd_digit_adj u_adj_tens (
        .d (sh_bcd[7:4]),
        .q (tens_adj)
    );

    bcd_digit_adj u_adj_units (
        .d (sh_bcd[3:0]),
        .q (units_adj)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_out <= '0;
                        if (in_valid) begin
                            bcd_reg <= bcd_in;
                            bin_reg <= '0;
                            cnt     <= CNT_W'(N_ITER);
                            err     <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    bcd_reg <= {tens_adj, units_adj};
                    bin_reg <= sh_bin;
                    cnt     <= cnt - 1'b1;
                    // Last shift: the binary register is complete after this edge.
                    if (cnt == CNT_W'(1)) begin
                        bin_out <= sh_bin;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = in_valid ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
